// File: rtl/vec_sched_pkg.sv
// Shared types and opcode constants for the vector instruction issue scheduler.
package vec_sched_pkg;

    localparam logic [6:0] OP_VLOAD  = 7'b0000111;
    localparam logic [6:0] OP_VSTORE = 7'b0100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FENCE_WAIT
    } sched_state_e;

    typedef enum logic [1:0] {
        CL_COMPUTE,
        CL_LOAD,
        CL_STORE,
        CL_FENCE
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cl;
        case (opcode)
            OP_VLOAD:  cl = CL_LOAD;
            OP_VSTORE: cl = CL_STORE;
            OP_FENCE:  cl = CL_FENCE;
            default:   cl = CL_COMPUTE;
        endcase
        return cl;
    endfunction

endpackage

// File: rtl/vec_issue_sched_fifo.sv
// Registered instruction FIFO with val/rdy on both sides; no push-to-pop bypass.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A pop frees its slot only on the next cycle, so readiness looks at the registered count.
    assign in_rdy  = !reset && (count != FULL_CNT);
    assign out_val = (count != '0);
    assign out_msg = mem[rd_ptr];
    assign push    = in_val && in_rdy;
    assign pop     = out_val && out_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_msg;
    end

endmodule

// File: rtl/vec_issue_sched.sv
// Issue scheduler: buffers instructions, tracks outstanding load/store beats,
// throttles memory ops against the beat window and holds FENCE until traffic drains.
module vec_issue_sched
    import vec_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int LD_BEATS = 2,
    parameter int ST_BEATS = 4,
    parameter int MAX_OUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_instr_msg,
    input  logic        in_instr_val,
    output logic        in_instr_rdy,
    output logic [31:0] out_instr_msg,
    output logic        out_instr_val,
    input  logic        out_instr_rdy,
    input  logic        ld_val,
    input  logic        ld_rdy,
    input  logic        st_val,
    input  logic        st_rdy,
    output logic        busy,
    output logic        fence_active,
    output logic [31:0] issued_cnt
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW:0]   LD_INC_W = (CW + 1)'(LD_BEATS);
    localparam logic [CW:0]   ST_INC_W = (CW + 1)'(ST_BEATS);
    localparam logic [CW:0]   MAX_W    = (CW + 1)'(MAX_OUT);
    localparam logic [CW-1:0] LD_INC   = CW'(LD_BEATS);
    localparam logic [CW-1:0] ST_INC   = CW'(ST_BEATS);

    sched_state_e  state;
    sched_state_e  state_nxt;
    instr_class_e  head_class;
    logic          head_val;
    logic [AW:0]   fifo_count;
    logic          push_fire;
    logic          issue_fire;
    logic          drained;
    logic          ld_ok;
    logic          st_ok;
    logic          val_int;
    logic [CW-1:0] ld_out;
    logic [CW-1:0] st_out;
    logic [CW-1:0] ld_sum;
    logic [CW-1:0] st_sum;

    sched_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_msg  (in_instr_msg),
        .in_val  (in_instr_val),
        .in_rdy  (in_instr_rdy),
        .out_msg (out_instr_msg),
        .out_val (head_val),
        .out_rdy (issue_fire),
        .count   (fifo_count)
    );

    assign head_class = classify(out_instr_msg[6:0]);
    assign push_fire  = in_instr_val && in_instr_rdy;
    assign drained    = (fifo_count == (AW + 1)'(1)) && !push_fire;

    // Widened compare keeps count + beats from wrapping past the window.
    assign ld_ok = ({1'b0, ld_out} + LD_INC_W) <= MAX_W;
    assign st_ok = ({1'b0, st_out} + ST_INC_W) <= MAX_W;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        val_int   = 1'b0;
        case (state)
            IDLE: begin
                if (head_val || push_fire) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!head_val) begin
                    if (!push_fire) state_nxt = IDLE;
                end else begin
                    case (head_class)
                        CL_FENCE:   state_nxt = FENCE_WAIT;
                        CL_LOAD:    val_int   = ld_ok;
                        CL_STORE:   val_int   = st_ok;
                        default:    val_int   = 1'b1;
                    endcase
                    if (val_int && out_instr_rdy && drained) state_nxt = IDLE;
                end
            end
            FENCE_WAIT: begin
                val_int = head_val && (ld_out == '0) && (st_out == '0);
                if (val_int && out_instr_rdy) state_nxt = drained ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_instr_val = val_int && !reset;
    assign issue_fire    = out_instr_val && out_instr_rdy;
    assign fence_active  = (state == FENCE_WAIT);
    assign busy          = head_val || (ld_out != '0) || (st_out != '0);

    // Issue credit is added before the snooped beat is removed, so a zero count only stays put when nothing was issued.
    assign ld_sum = ld_out + ((issue_fire && head_class == CL_LOAD)  ? LD_INC : '0);
    assign st_sum = st_out + ((issue_fire && head_class == CL_STORE) ? ST_INC : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ld_out     <= '0;
            st_out     <= '0;
            issued_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ld_out <= (ld_val && ld_rdy && ld_sum != '0) ? ld_sum - 1'b1 : ld_sum;
            st_out <= (st_val && st_rdy && st_sum != '0) ? st_sum - 1'b1 : st_sum;
            if (issue_fire) issued_cnt <= issued_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_vec_issue_sched.sv
// Directed bench for vec_issue_sched: default instance plus an LD_BEATS=4 instance sharing stimulus.
module tb_vec_issue_sched;

    logic        clk;
    logic        reset;
    logic [31:0] in_instr_msg;
    logic        in_instr_val;
    logic        out_instr_rdy;
    logic        ld_val, ld_rdy, st_val, st_rdy;

    logic        in_instr_rdy, out_instr_val, busy, fence_active;
    logic [31:0] out_instr_msg, issued_cnt;

    logic        in_instr_rdy4, out_instr_val4, busy4, fence_active4;
    logic [31:0] out_instr_msg4, issued_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    vec_issue_sched dut (
        .clk           (clk),
        .reset         (reset),
        .in_instr_msg  (in_instr_msg),
        .in_instr_val  (in_instr_val),
        .in_instr_rdy  (in_instr_rdy),
        .out_instr_msg (out_instr_msg),
        .out_instr_val (out_instr_val),
        .out_instr_rdy (out_instr_rdy),
        .ld_val        (ld_val),
        .ld_rdy        (ld_rdy),
        .st_val        (st_val),
        .st_rdy        (st_rdy),
        .busy          (busy),
        .fence_active  (fence_active),
        .issued_cnt    (issued_cnt)
    );

    vec_issue_sched #(.LD_BEATS(4)) dut4 (
        .clk           (clk),
        .reset         (reset),
        .in_instr_msg  (in_instr_msg),
        .in_instr_val  (in_instr_val),
        .in_instr_rdy  (in_instr_rdy4),
        .out_instr_msg (out_instr_msg4),
        .out_instr_val (out_instr_val4),
        .out_instr_rdy (out_instr_rdy),
        .ld_val        (ld_val),
        .ld_rdy        (ld_rdy),
        .st_val        (st_val),
        .st_rdy        (st_rdy),
        .busy          (busy4),
        .fence_active  (fence_active4),
        .issued_cnt    (issued_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st_fire(input logic on);
        st_val = on;
        st_rdy = on;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] got_q[$];
    logic [31:0] exp_msgs[5];

    initial begin
        reset = 1'b1; in_instr_msg = '0; in_instr_val = 1'b0; out_instr_rdy = 1'b0;
        ld_val = 1'b0; ld_rdy = 1'b0; st_val = 1'b0; st_rdy = 1'b0;

        // Reset state
        tick(); tick();
        check("rdy_in_reset", 32'(in_instr_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("rdy_after_reset",  32'(in_instr_rdy),  32'd1);
        check("val_after_reset",  32'(out_instr_val), 32'd0);
        check("busy_after_reset", 32'(busy),          32'd0);
        check("fence_after_reset",32'(fence_active),  32'd0);
        check("cnt_after_reset",  issued_cnt,         32'd0);

        // Single COMPUTE: visible one cycle after push
        out_instr_rdy = 1'b1;
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_0057;
        tick();
        in_instr_val = 1'b0;
        #1;
        check("c1_val", 32'(out_instr_val), 32'd1);
        check("c1_msg", out_instr_msg, 32'h0000_0057);
        tick();
        check("c1_cnt",  issued_cnt, 32'd1);
        check("c1_busy", 32'(busy),  32'd0);

        // Fill with out_instr_rdy low, then drain five in order
        out_instr_rdy = 1'b0;
        for (int i = 0; i < 5; i++) exp_msgs[i] = 32'h0000_0057 | (32'(i + 1) << 8);
        for (int i = 0; i < 4; i++) begin
            in_instr_val = 1'b1; in_instr_msg = exp_msgs[i];
            tick();
        end
        in_instr_msg = exp_msgs[4];
        #1;
        check("full_rdy",  32'(in_instr_rdy),  32'd0);
        check("full_val",  32'(out_instr_val), 32'd1);
        check("full_head", out_instr_msg, exp_msgs[0]);
        out_instr_rdy = 1'b1;
        got_q.delete();
        for (int c = 0; c < 12; c++) begin
            logic fo, fi;
            #1;
            fo = out_instr_val && out_instr_rdy;
            fi = in_instr_val && in_instr_rdy;
            if (fo) got_q.push_back(out_instr_msg);
            tick();
            if (fi) in_instr_val = 1'b0;
        end
        check("drain_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) check($sformatf("drain_msg%0d", i), got_q[i], exp_msgs[i]);
        check("drain_cnt",  issued_cnt, 32'd6);
        check("drain_busy", 32'(busy),  32'd0);

        // STORE then FENCE: fence waits for store beats to drain
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_0027;
        tick();
        in_instr_msg = 32'h0000_000F;
        tick();
        in_instr_val = 1'b0;
        #1;
        check("fence_not_direct", 32'(out_instr_val), 32'd0);
        tick();
        check("fence_active", 32'(fence_active), 32'd1);
        check("fence_st_out", 32'(dut.st_out),   32'd4);
        check("fence_hold",   32'(out_instr_val), 32'd0);
        st_fire(1'b1);
        tick(); tick(); tick();
        check("fence_hold_st1", 32'(out_instr_val), 32'd0);
        tick();
        st_fire(1'b0);
        #1;
        check("fence_present", 32'(out_instr_val), 32'd1);
        check("fence_msg",     out_instr_msg, 32'h0000_000F);
        tick();
        check("fence_done", 32'(fence_active), 32'd0);
        check("fence_cnt",  issued_cnt, 32'd8);
        check("fence_busy", 32'(busy), 32'd0);

        // STORE issue coincident with a store beat, then saturation at zero
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_1027;
        tick();
        in_instr_val = 1'b0;
        tick();
        st_fire(1'b1);
        tick(); tick();
        st_fire(1'b0);
        #1;
        check("st_out_2", 32'(dut.st_out), 32'd2);
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_2027;
        tick();
        in_instr_val = 1'b0;
        st_fire(1'b1);
        #1;
        check("st_coinc_val", 32'(out_instr_val), 32'd1);
        tick();
        st_fire(1'b0);
        #1;
        check("st_coinc_out", 32'(dut.st_out), 32'd5);
        st_fire(1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("st_drain0", 32'(dut.st_out), 32'd0);
        tick();
        st_fire(1'b0);
        #1;
        check("st_sat0", 32'(dut.st_out), 32'd0);
        check("st_busy", 32'(busy), 32'd0);

        // LOAD throttling: default window takes all four, LD_BEATS=4 stalls the fourth
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ld_reset_cnt", issued_cnt4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_instr_val = 1'b1; in_instr_msg = (32'(i) << 12) | 32'h0000_0007;
            tick();
        end
        in_instr_val = 1'b0;
        tick(); tick(); tick();
        check("ld_out_b2",   32'(dut.ld_out),  32'd8);
        check("ld_cnt_b2",   issued_cnt,       32'd4);
        check("ld_out_b4",   32'(dut4.ld_out), 32'd12);
        check("ld_cnt_b4",   issued_cnt4,      32'd3);
        check("ld_stall_b4", 32'(out_instr_val4), 32'd0);
        check("ld_head_b4",  out_instr_msg4,   32'h0000_3007);
        ld_val = 1'b1; ld_rdy = 1'b1;
        tick();
        ld_val = 1'b0; ld_rdy = 1'b0;
        #1;
        check("ld_out_b4_11", 32'(dut4.ld_out),    32'd11);
        check("ld_go_b4",     32'(out_instr_val4), 32'd1);
        tick();
        check("ld_out_b4_15", 32'(dut4.ld_out), 32'd15);
        check("ld_cnt_b4_4",  issued_cnt4,      32'd4);
        check("ld_out_b2_7",  32'(dut.ld_out),  32'd7);

        // Reset mid-operation with three queued entries and st_out=3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_0027;
        tick();
        in_instr_val = 1'b0;
        tick();
        st_fire(1'b1);
        tick();
        st_fire(1'b0);
        out_instr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_instr_val = 1'b1; in_instr_msg = 32'h0000_0057 | (32'(i) << 20);
            tick();
        end
        in_instr_val = 1'b0;
        #1;
        check("pre_rst_st_out", 32'(dut.st_out),   32'd3);
        check("pre_rst_val",    32'(out_instr_val), 32'd1);
        check("pre_rst_busy",   32'(busy),          32'd1);
        reset = 1'b1;
        #1;
        check("in_rst_rdy", 32'(in_instr_rdy),  32'd0);
        check("in_rst_val", 32'(out_instr_val), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_val",   32'(out_instr_val), 32'd0);
        check("post_rst_busy",  32'(busy),          32'd0);
        check("post_rst_cnt",   issued_cnt,         32'd0);
        check("post_rst_rdy",   32'(in_instr_rdy),  32'd1);
        check("post_rst_st",    32'(dut.st_out),    32'd0);
        out_instr_rdy = 1'b1;
        in_instr_val = 1'b1; in_instr_msg = 32'h0000_0157;
        tick();
        in_instr_val = 1'b0;
        #1;
        check("post_rst_msg", out_instr_msg, 32'h0000_0157);
        tick();
        check("post_rst_cnt1",  issued_cnt, 32'd1);
        check("post_rst_busy1", 32'(busy),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
